// File: rtl/battle_pkg.sv
// Shared constants and types for the battle game tile layers.
// Holds the map geometry, the VGA visible area and the packed map-bus type
// used to hand whole strong-brick maps between blocks.
package battle_pkg;

    localparam int MAP_ROWS  = 15;
    localparam int MAP_COLS  = 20;
    localparam int TILE_LOG2 = 5;

    // Visible VGA area, sized to match the 11-bit pixel coordinates.
    localparam logic [10:0] SCREEN_W = 11'd640;
    localparam logic [10:0] SCREEN_H = 11'd480;

    // One full map: index [row][col], row 0 at the top, column 0 leftmost.
    typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0] map_t;

    // Loader state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } ld_state_t;

endpackage

// File: rtl/strong_bricks_matrix.sv
// Strong-brick tile matrix.
// Holds the live strong-brick map, loads it row by row from one of four
// static maps, answers per-pixel draw lookups and bullet-impact queries.
// Optional feature macro: STRONG_DESTRUCT_EN -- when defined, a powered hit
// on a live strong brick clears that brick; otherwise queries are read-only.
// The map ports use battle_pkg::map_t, so ROWS/COLS must match the package.
module strong_bricks_matrix
    import battle_pkg::*;
#(
    parameter int COLS      = MAP_COLS,
    parameter int ROWS      = MAP_ROWS,
    parameter int TILE_LOG2 = battle_pkg::TILE_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  map_t                 mat_in0,
    input  map_t                 mat_in1,
    input  map_t                 mat_in2,
    input  map_t                 mat_in3,
    input  logic [1:0]           map_sel,
    input  logic                 load_req,
    output logic                 busy,
    output logic                 load_done,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    output logic                 drawingRequest,
    output logic [TILE_LOG2-1:0] offsetX,
    output logic [TILE_LOG2-1:0] offsetY,
    input  logic                 hit_valid,
    input  logic [3:0]           hit_row,
    input  logic [4:0]           hit_col,
    input  logic                 hit_power,
    output logic                 hit_ready,
    output logic                 hit_ack,
    output logic                 hit_strong
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    ld_state_t     state;
    logic [RW-1:0] row_cnt;
    logic [1:0]    sel_q;
    map_t          live;
    map_t          src_map;

    logic [10:0]   tile_x;
    logic [10:0]   tile_y;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic          pix_in_map;
    logic          pix_cell;

    logic          hit_accept;
    logic          hit_in_map;
    logic          hit_cell;

    assign hit_ready  = ~busy;
    assign hit_accept = hit_valid & ~busy;

    // Map selected at load start; map_sel is latched so later changes are ignored.
    always_comb begin
        case (sel_q)
            2'd0:    src_map = mat_in0;
            2'd1:    src_map = mat_in1;
            2'd2:    src_map = mat_in2;
            default: src_map = mat_in3;
        endcase
    end

    // Pixel-to-tile lookup; cells outside the visible area or map read as empty.
    always_comb begin
        tile_x     = pixelX >> TILE_LOG2;
        tile_y     = pixelY >> TILE_LOG2;
        pix_row    = RW'(tile_y);
        pix_col    = CW'(tile_x);
        pix_in_map = (pixelX < SCREEN_W) && (pixelY < SCREEN_H) &&
                     (int'(tile_y) < ROWS) && (int'(tile_x) < COLS);
        pix_cell   = 1'b0;
        if (pix_in_map)
            pix_cell = live[pix_row][pix_col];
    end

    // Query-cell lookup; out-of-range coordinates are treated as no brick.
    always_comb begin
        hit_in_map = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
        hit_cell   = 1'b0;
        if (hit_in_map)
            hit_cell = live[hit_row][hit_col];
    end

`ifdef STRONG_DESTRUCT_EN
    logic hit_clear;
    assign hit_clear = hit_accept & hit_cell & hit_power;
`else
    // hit_power has no effect when bricks are indestructible.
    logic unused_hit_power;
    assign unused_hit_power = hit_power;
`endif

    // Loader FSM: one row per cycle into the live matrix, plus hit-driven clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            load_done <= 1'b0;
            row_cnt   <= '0;
            sel_q     <= 2'd0;
            live      <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state   <= ST_LOAD;
                        busy    <= 1'b1;
                        row_cnt <= '0;
                        sel_q   <= map_sel;
                    end
                end
                ST_LOAD: begin
                    live[row_cnt] <= src_map[row_cnt];
                    if (row_cnt == LAST_ROW) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef STRONG_DESTRUCT_EN
            // Queries are only accepted in IDLE, so this never races a row copy.
            if (hit_clear)
                live[hit_row][hit_col] <= 1'b0;
`endif
        end
    end

    // Registered draw request and in-tile offsets, suppressed while loading.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            offsetX        <= '0;
            offsetY        <= '0;
        end else begin
            drawingRequest <= pix_cell & ~busy;
            offsetX        <= pixelX[TILE_LOG2-1:0];
            offsetY        <= pixelY[TILE_LOG2-1:0];
        end
    end

    // Registered query response, reporting the cell value before any clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_ack    <= 1'b0;
            hit_strong <= 1'b0;
        end else begin
            hit_ack    <= hit_accept;
            hit_strong <= hit_accept & hit_cell;
        end
    end

endmodule

// File: tb/tb_strong_bricks_matrix.sv
// Self-checking bench for strong_bricks_matrix.
// A cycle-level behavioural model (remaining-load countdown plus a plain
// bit array) predicts every output; directed sequences add literal checks.
module tb_strong_bricks_matrix;
    import battle_pkg::*;

    localparam int ROWS = 15;
    localparam int COLS = 20;
`ifdef STRONG_DESTRUCT_EN
    localparam bit DESTRUCT = 1'b1;
`else
    localparam bit DESTRUCT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    map_t        mat [4];
    logic [1:0]  map_sel;
    logic        load_req;
    logic        busy;
    logic        load_done;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        drawingRequest;
    logic [4:0]  offsetX;
    logic [4:0]  offsetY;
    logic        hit_valid;
    logic [3:0]  hit_row;
    logic [4:0]  hit_col;
    logic        hit_power;
    logic        hit_ready;
    logic        hit_ack;
    logic        hit_strong;

    int n_checks = 0;
    int n_err    = 0;

    strong_bricks_matrix dut (
        .clk(clk), .reset(reset),
        .mat_in0(mat[0]), .mat_in1(mat[1]), .mat_in2(mat[2]), .mat_in3(mat[3]),
        .map_sel(map_sel), .load_req(load_req), .busy(busy), .load_done(load_done),
        .pixelX(pixelX), .pixelY(pixelY), .drawingRequest(drawingRequest),
        .offsetX(offsetX), .offsetY(offsetY),
        .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
        .hit_power(hit_power), .hit_ready(hit_ready), .hit_ack(hit_ack),
        .hit_strong(hit_strong)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_live [ROWS][COLS];
    int m_left;
    int m_sel;
    bit exp_busy, exp_done, exp_draw, exp_ack, exp_strong;
    int exp_offx, exp_offy;

    always @(posedge clk or posedge reset) begin : model
        int r, c;
        bit acc;
        if (reset) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    m_live[i][j] = 1'b0;
            m_left = 0; m_sel = 0;
            exp_busy = 0; exp_done = 0; exp_draw = 0; exp_ack = 0; exp_strong = 0;
            exp_offx = 0; exp_offy = 0;
        end else begin
            exp_offx = int'(pixelX) % 32;
            exp_offy = int'(pixelY) % 32;
            r = int'(pixelY) / 32;
            c = int'(pixelX) / 32;
            exp_draw = 1'b0;
            if (pixelX < 640 && pixelY < 480 && m_left == 0)
                exp_draw = m_live[r][c];
            acc = hit_valid && (m_left == 0);
            exp_ack = acc;
            exp_strong = 1'b0;
            if (acc && int'(hit_row) < ROWS && int'(hit_col) < COLS)
                exp_strong = m_live[hit_row][hit_col];
            exp_done = (m_left == 1);
            if (m_left > 0) begin
                for (int j = 0; j < COLS; j++)
                    m_live[ROWS - m_left][j] = mat[m_sel][ROWS - m_left][j];
                m_left--;
            end else if (load_req) begin
                m_left = ROWS;
                m_sel = int'(map_sel);
            end
            if (DESTRUCT && exp_strong && hit_power)
                m_live[hit_row][hit_col] = 1'b0;
            exp_busy = (m_left != 0);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, exp_busy);
            chk("load_done", load_done, exp_done);
            chk("hit_ready", hit_ready, !exp_busy);
            chk("drawingRequest", drawingRequest, exp_draw);
            chk("offsetX", offsetX, exp_offx);
            chk("offsetY", offsetY, exp_offy);
            chk("hit_ack", hit_ack, exp_ack);
            chk("hit_strong", hit_strong, exp_strong);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_px(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    task automatic do_hit(input int r, input int c, input bit p);
        hit_valid = 1'b1;
        hit_row = 4'(r);
        hit_col = 5'(c);
        hit_power = p;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    // Starts a load; optionally re-requests with another map_sel and
    // pokes a hit while busy. Checks busy length and the done pulse.
    task automatic do_load(input int sel, input int extra_at, input int hit_at);
        int n;
        map_sel = 2'(sel);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == extra_at) begin
                load_req = 1'b1;
                map_sel = 2'(sel + 1);
            end else begin
                load_req = 1'b0;
            end
            if (n == hit_at) begin
                hit_valid = 1'b1; hit_row = 4'd4; hit_col = 5'd13; hit_power = 1'b0;
            end else begin
                hit_valid = 1'b0;
            end
            if (n == hit_at + 1)
                chk("hit_ack_while_busy", hit_ack, 0);
            @(negedge clk);
            n++;
        end
        load_req = 1'b0;
        hit_valid = 1'b0;
        chk("busy_cycles", n, 15);
        chk("load_done_at_fall", load_done, 1);
        @(negedge clk);
        chk("load_done_one_cycle", load_done, 0);
        chk("no_reload", busy, 0);
    endtask

    task automatic scan(input map_t ref_m, input string nm);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                set_px(c * 32 + 5, r * 32 + 7);
                @(negedge clk);
                chk(nm, drawingRequest, ref_m[r][c]);
            end
    endtask

    initial begin : stim
        map_t zero_m;
        int n;
        zero_m = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mat[0][r][c] = ((r + c) % 4 == 0);
                mat[1][r][c] = ((r * 3 + c * 5) % 7 < 3);
            end
        mat[1][4][13] = 1'b1;
        mat[1][4][12] = 1'b0;
        mat[2] = ~mat[1];
        mat[3] = '1;

        reset = 1'b1;
        map_sel = 2'd0; load_req = 1'b0;
        set_px(420, 140);
        hit_valid = 1'b1; hit_row = 4'd4; hit_col = 5'd13; hit_power = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_draw", drawingRequest, 0);
        chk("rst_offsetX", offsetX, 0);
        chk("rst_offsetY", offsetY, 0);
        chk("rst_hit_ack", hit_ack, 0);
        chk("rst_hit_strong", hit_strong, 0);
        hit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Plain load of map 1, then whole-matrix readback through pixels.
        do_load(1, -1, -1);
        scan(mat[1], "scan_map1");

        set_px(420, 140);
        @(negedge clk);
        chk("px_draw", drawingRequest, 1);
        chk("px_offX", offsetX, 4);
        chk("px_offY", offsetY, 12);
        set_px(700, 140);
        @(negedge clk);
        chk("px_offscreen_x", drawingRequest, 0);
        set_px(100, 480);
        @(negedge clk);
        chk("px_offscreen_y", drawingRequest, 0);

        // Powered hit coinciding with the pixel lookup of the same cell.
        set_px(420, 140);
        do_hit(4, 13, 1'b1);
        chk("hit1_ack", hit_ack, 1);
        chk("hit1_strong", hit_strong, 1);
        chk("hit1_draw_preclear", drawingRequest, 1);
        @(negedge clk);
        chk("hit_ack_pulse", hit_ack, 0);
        chk("draw_after_hit", drawingRequest, DESTRUCT ? 0 : 1);
        do_hit(4, 13, 1'b1);
        chk("hit2_ack", hit_ack, 1);
        chk("hit2_strong", hit_strong, DESTRUCT ? 0 : 1);
        do_hit(15, 5, 1'b1);
        chk("hit_row_oob_ack", hit_ack, 1);
        chk("hit_row_oob_strong", hit_strong, 0);
        do_hit(3, 20, 1'b1);
        chk("hit_col_oob_ack", hit_ack, 1);
        chk("hit_col_oob_strong", hit_strong, 0);
        do_hit(4, 12, 1'b1);
        chk("hit_empty_strong", hit_strong, 0);

        // Load of map 2 with a re-request, map_sel change and hit while busy.
        do_load(2, 5, 3);
        scan(mat[2], "scan_map2");

        // Reset in load cycle 7 of a map-3 load.
        map_sel = 2'd3;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load_done", load_done, 0);
        chk("mid_rst_draw", drawingRequest, 0);
        chk("mid_rst_offX", offsetX, 0);
        chk("mid_rst_hit_ack", hit_ack, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_done) n++;
        end
        chk("mid_rst_no_done", n, 0);
        scan(zero_m, "scan_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/strong_bricks_matrix.md
STRONG_BRICKS_MATRIX -- requirements
Module: strong_bricks_matrix

Interface
REQ-001 SHALL have parameter COLS, default 20, meaning tile columns per map.
REQ-002 SHALL have parameter ROWS, default 15, meaning tile rows per map.
REQ-003 SHALL have parameter TILE_LOG2, default 5, meaning log2 of tile edge in pixels (32x32 tiles).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports mat_in0..mat_in3  in  ROWS x COLS each  four static strong-brick maps, row 0 first, column 0 leftmost.
REQ-007 SHALL have port map_sel  in  2  map to load, sampled only on an accepted load_req.
REQ-008 SHALL have port load_req  in  1  one-cycle load request.
REQ-009 SHALL have port busy  out  1  high while a load is in progress.
REQ-010 SHALL have port load_done  out  1  one-cycle pulse when a load completes.
REQ-011 SHALL have ports pixelX, pixelY  in  11 each  current VGA pixel.
REQ-012 SHALL have port drawingRequest  out  1  registered: current pixel lies on a live strong brick.
REQ-013 SHALL have ports offsetX, offsetY  out  TILE_LOG2 each  registered pixel offset inside the tile.
REQ-014 SHALL have ports hit_valid, hit_row (4), hit_col (5), hit_power (1)  in  bullet-impact query.
REQ-015 SHALL have port hit_ready  out  1  equal to NOT busy.
REQ-016 SHALL have ports hit_ack, hit_strong  out  1 each  registered query response.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and LOAD; IDLE -> LOAD on load_req in IDLE; LOAD -> IDLE after row ROWS-1 is written.
REQ-018 SHALL, in LOAD, copy one row per cycle from the selected map into the live matrix, rows 0..ROWS-1 in order, taking exactly 15 cycles.
REQ-019 SHALL assert busy in the cycle after load_req is accepted and keep it high for exactly 15 cycles.
REQ-020 SHALL pulse load_done for one cycle in the cycle busy falls.
REQ-021 SHALL ignore load_req while busy; map_sel changes mid-load SHALL have no effect.
REQ-022 SHALL compute col = pixelX>>TILE_LOG2 and row = pixelY>>TILE_LOG2, and register drawingRequest = live[row][col] with 1-cycle latency.
REQ-023 SHALL force drawingRequest to 0 when pixelX >= 640, pixelY >= 480, or busy.
REQ-024 SHALL register offsetX = pixelX[TILE_LOG2-1:0] and offsetY = pixelY[TILE_LOG2-1:0] with the same latency.
REQ-025 SHALL accept a query when hit_valid && hit_ready, and one cycle later pulse hit_ack with hit_strong = live[hit_row][hit_col].
REQ-026 SHALL treat hit_row >= ROWS or hit_col >= COLS as a non-brick: hit_ack = 1, hit_strong = 0, no state change.
REQ-027 SHALL, when a hit on a live cell with hit_power = 1 coincides with the pixel lookup of that same cell, return the pre-clear value on drawingRequest.

Reset
REQ-028 SHALL, on reset, clear the live matrix to all zeros, enter IDLE, and drive busy, load_done, drawingRequest, offsetX, offsetY, hit_ack and hit_strong to 0.
REQ-029 SHALL, on reset asserted mid-load, abandon the load and leave the matrix all zeros; no load_done is issued.

Configuration
REQ-030 SHALL, with STRONG_DESTRUCT_EN defined, clear live[hit_row][hit_col] in the ack cycle when an accepted query hits a live cell with hit_power = 1.
REQ-031 SHALL, without STRONG_DESTRUCT_EN, never modify the live matrix on a query; hit_power is ignored and hit_strong is still reported.

Structure
REQ-032 SHALL take MAP_ROWS, MAP_COLS, TILE_LOG2, SCREEN_W = 640, SCREEN_H = 480 and the map-bus typedef from the shared battle_pkg package.
REQ-033 SHALL be a single module with no sub-modules; the FSM and row counter are inline.

Verification
REQ-034 SHALL verify load timing: map_sel = 1, load_req pulse -> busy high for 15 cycles, then load_done pulse; live equals mat_in1.
REQ-035 SHALL verify pixel lookup: after loading a map with cell [4][13] = 1, pixel (420,140) -> drawingRequest = 1, offsetX = 4, offsetY = 12 one cycle later; pixel (700,140) -> 0.
REQ-036 SHALL verify hit with destruction: with STRONG_DESTRUCT_EN defined, hit (4,13,power = 1) -> hit_ack = 1, hit_strong = 1; a repeat of the same hit -> hit_strong = 0.
REQ-037 SHALL verify hit without the macro: the same hit twice -> hit_strong = 1 both times.
REQ-038 SHALL verify busy interaction: load_req during load -> ignored, load still takes 15 cycles; hit_valid during busy -> no hit_ack.
REQ-039 SHALL verify mid-load reset: reset asserted in load cycle 7 -> all outputs 0, matrix all zero, no load_done.
